// File: rtl/tlp_sched_pkg.sv
// Shared types and helpers for the TLP request scheduler.
// Field widths here must match the scheduler's ADDR_WIDTH / DATA_WIDTH.
package tlp_sched_pkg;

    localparam int unsigned TLP_ADDR_W = 32;
    localparam int unsigned TLP_DATA_W = 1024;
    localparam int unsigned PD_UNIT_DW = 4;

    typedef struct packed {
        logic                  is_memwrite;
        logic [TLP_ADDR_W-1:0] addr;
        logic [7:0]            length;
        logic [15:0]           bdf;
        logic [TLP_DATA_W-1:0] data;
    } tlp_req_t;

    // Posted-data credits consumed by a write of len DW (rounded up to whole units).
    function automatic logic [7:0] pd_need(input logic [7:0] len);
        logic [8:0] sum;
        sum = {1'b0, len} + 9'(PD_UNIT_DW - 1);
        return 8'(sum >> $clog2(PD_UNIT_DW));
    endfunction

endpackage

// File: rtl/tlp_credit_counter.sv
// Flow-control credit counter: debit at grant, return from the link partner,
// both in the same cycle; returns clamp at the initial (maximum) value.
module tlp_credit_counter
    import tlp_sched_pkg::*;
#(
    parameter int unsigned INIT  = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RET_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] debit,
    input  logic [RET_W-1:0] ret,
    output logic [WIDTH-1:0] avail
);

    localparam logic [WIDTH:0] L_INIT = (WIDTH+1)'(INIT);

    logic [WIDTH-1:0] r_avail;
    logic [WIDTH:0]   w_sum;

    always_comb begin
        w_sum = {1'b0, r_avail} - {1'b0, debit} + (WIDTH+1)'(ret);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_avail <= L_INIT[WIDTH-1:0];
        end else if (w_sum > L_INIT) begin
            r_avail <= L_INIT[WIDTH-1:0];
        end else begin
            r_avail <= w_sum[WIDTH-1:0];
        end
    end

    assign avail = r_avail;

    a_ret_overflow: assert property (@(posedge clk) disable iff (!rst_n) w_sum <= L_INIT);
    a_debit_underflow: assert property (@(posedge clk) disable iff (!rst_n) debit <= r_avail);

endmodule

// File: rtl/tlp_req_scheduler.sv
// Arbitrates decoded AXI write chunks and reads into a single registered
// TLP request slot, gated by posted / non-posted flow-control credits.
module tlp_req_scheduler
    import tlp_sched_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 1024,
    parameter int unsigned WR_BURST_MAX = 4,
    parameter int unsigned PH_INIT      = 8,
    parameter int unsigned PD_INIT      = 64,
    parameter int unsigned NPH_INIT     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_length,
    input  logic [15:0]           wr_bdf,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_length,
    input  logic [15:0]           rd_bdf,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_is_memwrite,
    output logic [ADDR_WIDTH-1:0] tx_addr,
    output logic [7:0]            tx_length,
    output logic [15:0]           tx_bdf,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  ph_ret,
    input  logic [3:0]            pd_ret,
    input  logic                  nph_ret,
    output logic [7:0]            ph_avail,
    output logic [11:0]           pd_avail,
    output logic [7:0]            nph_avail
);

    typedef enum logic {S_EMPTY, S_FULL} slot_state_e;

    localparam int unsigned         BURST_W     = $clog2(WR_BURST_MAX + 1);
    localparam logic [BURST_W-1:0]  L_BURST_MAX = BURST_W'(WR_BURST_MAX);

    slot_state_e        r_state, w_state_nxt;
    tlp_req_t           r_req, w_req_nxt;
    logic [BURST_W-1:0] r_burst;

    logic       w_can_load, w_wr_elig, w_rd_elig, w_wr_grant, w_rd_grant;
    logic [7:0] w_need;

    assign w_need    = pd_need(wr_length);
    assign w_wr_elig = wr_valid && (ph_avail != '0) && (pd_avail >= {4'b0, w_need});
    assign w_rd_elig = rd_valid && (nph_avail != '0);
    assign w_can_load = (r_state == S_EMPTY) || (tx_valid && tx_ready);

    // Write wins ties until it has run WR_BURST_MAX grants past a waiting read.
    assign w_wr_grant = rst_n && w_can_load && w_wr_elig && !(w_rd_elig && r_burst == L_BURST_MAX);
    assign w_rd_grant = rst_n && w_can_load && w_rd_elig && !w_wr_grant;

    assign wr_ready = w_wr_grant;
    assign rd_ready = w_rd_grant;

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        if (w_wr_grant) begin
            w_state_nxt           = S_FULL;
            w_req_nxt.is_memwrite = 1'b1;
            w_req_nxt.addr        = wr_addr;
            w_req_nxt.length      = wr_length;
            w_req_nxt.bdf         = wr_bdf;
            w_req_nxt.data        = wr_data;
        end else if (w_rd_grant) begin
            w_state_nxt           = S_FULL;
            w_req_nxt.is_memwrite = 1'b0;
            w_req_nxt.addr        = rd_addr;
            w_req_nxt.length      = rd_length;
            w_req_nxt.bdf         = rd_bdf;
            w_req_nxt.data        = '0;
        end else if (tx_valid && tx_ready) begin
            w_state_nxt = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_req   <= '0;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            if (w_rd_grant || !rd_valid) begin
                r_burst <= '0;
            end else if (w_wr_grant && w_rd_elig && r_burst != L_BURST_MAX) begin
                r_burst <= r_burst + BURST_W'(1);
            end
        end
    end

    assign tx_valid       = (r_state == S_FULL);
    assign tx_is_memwrite = r_req.is_memwrite;
    assign tx_addr        = r_req.addr;
    assign tx_length      = r_req.length;
    assign tx_bdf         = r_req.bdf;
    assign tx_data        = r_req.data;

    tlp_credit_counter #(.INIT(PH_INIT), .WIDTH(8), .RET_W(1)) u_ph (
        .clk(clk), .rst_n(rst_n), .debit({7'b0, w_wr_grant}), .ret(ph_ret), .avail(ph_avail)
    );

    tlp_credit_counter #(.INIT(PD_INIT), .WIDTH(12), .RET_W(4)) u_pd (
        .clk(clk), .rst_n(rst_n), .debit(w_wr_grant ? {4'b0, w_need} : 12'd0), .ret(pd_ret),
        .avail(pd_avail)
    );

    tlp_credit_counter #(.INIT(NPH_INIT), .WIDTH(8), .RET_W(1)) u_nph (
        .clk(clk), .rst_n(rst_n), .debit({7'b0, w_rd_grant}), .ret(nph_ret), .avail(nph_avail)
    );

    a_wr_len: assert property (@(posedge clk) disable iff (!rst_n)
        wr_valid |-> (wr_length >= 8'd1 && wr_length <= 8'd32));
    a_rd_len: assert property (@(posedge clk) disable iff (!rst_n)
        rd_valid |-> (rd_length >= 8'd1 && rd_length <= 8'd32));

endmodule

// File: tb/tb_tlp_req_scheduler.sv
// Directed bench for tlp_req_scheduler with a transaction-level reference model.
module tb_tlp_req_scheduler;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid, wr_ready, rd_valid, rd_ready;
    logic [31:0]   wr_addr, rd_addr, tx_addr;
    logic [7:0]    wr_length, rd_length, tx_length;
    logic [15:0]   wr_bdf, rd_bdf, tx_bdf;
    logic [1023:0] wr_data, tx_data;
    logic          tx_valid, tx_ready, tx_is_memwrite;
    logic          ph_ret, nph_ret;
    logic [3:0]    pd_ret;
    logic [7:0]    ph_avail, nph_avail;
    logic [11:0]   pd_avail;

    tlp_req_scheduler #(
        .ADDR_WIDTH(32), .DATA_WIDTH(1024), .WR_BURST_MAX(4),
        .PH_INIT(8), .PD_INIT(64), .NPH_INIT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_length(wr_length),
        .wr_bdf(wr_bdf), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_length(rd_length),
        .rd_bdf(rd_bdf),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_is_memwrite(tx_is_memwrite),
        .tx_addr(tx_addr), .tx_length(tx_length), .tx_bdf(tx_bdf), .tx_data(tx_data),
        .ph_ret(ph_ret), .pd_ret(pd_ret), .nph_ret(nph_ret),
        .ph_avail(ph_avail), .pd_avail(pd_avail), .nph_avail(nph_avail)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    bit    chk_en = 0;
    bit    auto_h = 0;
    bit    auto_d = 0;
    string glog = "";

    // Reference model: credit pools as plain integers, one request slot.
    int            m_ph = 8, m_pd = 64, m_nph = 8, m_burst = 0;
    bit            m_full = 0, m_wr = 0;
    logic [31:0]   m_addr = '0;
    logic [7:0]    m_len = '0;
    logic [15:0]   m_bdf = '0;
    logic [1023:0] m_data = '0;

    function automatic int need(input int len);
        return (len + 3) / 4;
    endfunction

    // 0 = no grant, 1 = write, 2 = read
    function automatic int pick();
        bit can, we, re;
        if (!rst_n) return 0;
        can = !m_full || tx_ready;
        we  = wr_valid && m_ph >= 1 && m_pd >= need(int'(wr_length));
        re  = rd_valid && m_nph >= 1;
        if (!can) return 0;
        if (we && re) return (m_burst >= 4) ? 2 : 1;
        if (we) return 1;
        if (re) return 2;
        return 0;
    endfunction

    function automatic logic [1023:0] mk_data(input logic [31:0] seed);
        logic [1023:0] d;
        for (int i = 0; i < 32; i++) d[i*32 +: 32] = seed ^ (32'h9e37_79b9 * i);
        return d;
    endfunction

    always @(posedge clk) begin
        int g;
        bit re;
        g  = pick();
        re = rd_valid && m_nph >= 1;
        if (!rst_n) begin
            m_ph = 8; m_pd = 64; m_nph = 8; m_burst = 0;
            m_full = 0; m_wr = 0; m_addr = '0; m_len = '0; m_bdf = '0; m_data = '0;
        end else begin
            if (g == 2 || !rd_valid) m_burst = 0;
            else if (g == 1 && re && m_burst < 4) m_burst = m_burst + 1;
            if (g == 1) begin
                m_full = 1; m_wr = 1; m_addr = wr_addr; m_len = wr_length;
                m_bdf = wr_bdf; m_data = wr_data;
                m_ph = m_ph - 1; m_pd = m_pd - need(int'(wr_length));
                glog = {glog, "W"};
            end else if (g == 2) begin
                m_full = 1; m_wr = 0; m_addr = rd_addr; m_len = rd_length;
                m_bdf = rd_bdf; m_data = '0;
                m_nph = m_nph - 1;
                glog = {glog, "R"};
            end else if (m_full && tx_ready) begin
                m_full = 0;
            end
            m_ph  = m_ph + int'(ph_ret);    if (m_ph > 8) m_ph = 8;
            m_pd  = m_pd + int'(pd_ret);    if (m_pd > 64) m_pd = 64;
            m_nph = m_nph + int'(nph_ret);  if (m_nph > 8) m_nph = 8;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_data(input logic [1023:0] act, input logic [1023:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL tx_data: got low128 %h expected low128 %h at %0t",
                     act[127:0], exp[127:0], $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int g;
            g = pick();
            chk("tx_valid", tx_valid, m_full);
            chk("wr_ready", wr_ready, g == 1);
            chk("rd_ready", rd_ready, g == 2);
            chk("ph_avail", ph_avail, m_ph);
            chk("pd_avail", pd_avail, m_pd);
            chk("nph_avail", nph_avail, m_nph);
            if (m_full) begin
                chk("tx_is_memwrite", tx_is_memwrite, m_wr);
                chk("tx_addr", tx_addr, m_addr);
                chk("tx_length", tx_length, m_len);
                chk("tx_bdf", tx_bdf, m_bdf);
                chk_data(tx_data, m_data);
            end
        end
    end

    // Advance one clock; auto-returns model a link partner freeing credits on acceptance.
    task automatic cyc();
        if (auto_h) begin
            ph_ret  = m_full && tx_ready && m_wr;
            nph_ret = m_full && tx_ready && !m_wr;
        end
        if (auto_d) pd_ret = (m_full && tx_ready && m_wr) ? 4'(need(int'(m_len))) : 4'd0;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; tx_ready = 1'b0;
        wr_addr = '0; wr_length = 8'd1; wr_bdf = '0; wr_data = '0;
        rd_addr = '0; rd_length = 8'd1; rd_bdf = '0;
        ph_ret = 1'b0; pd_ret = 4'd0; nph_ret = 1'b0;

        // Reset held for two cycles
        @(posedge clk); #2;
        chk_en = 1;
        cyc();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_ph", ph_avail, 8);
        chk("rst_pd", pd_avail, 64);
        chk("rst_nph", nph_avail, 8);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 0);

        // Single write, len 32
        rst_n = 1'b1; rd_valid = 1'b0; tx_ready = 1'b1;
        wr_addr = 32'h1000_0040; wr_length = 8'd32; wr_bdf = 16'h0100;
        wr_data = mk_data(32'h1234_5678);
        #1 chk("w1_wr_ready", wr_ready, 1);
        cyc();
        wr_valid = 1'b0;
        #1;
        chk("w1_tx_valid", tx_valid, 1);
        chk("w1_is_mwr", tx_is_memwrite, 1);
        chk("w1_addr", tx_addr, 32'h1000_0040);
        chk("w1_dw0", tx_data[31:0], 32'h1234_5678);
        chk("w1_ph", ph_avail, 7);
        chk("w1_pd", pd_avail, 56);
        cyc();
        ph_ret = 1'b1; pd_ret = 4'd8;
        cyc();
        ph_ret = 1'b0; pd_ret = 4'd0;
        #1;
        chk("w1_ph_back", ph_avail, 8);
        chk("w1_pd_back", pd_avail, 64);
        chk("w1_tx_empty", tx_valid, 0);

        // Continuous write + read contention
        auto_h = 1; auto_d = 1; glog = "";
        wr_valid = 1'b1; wr_length = 8'd4; wr_bdf = 16'h0208;
        rd_valid = 1'b1; rd_length = 8'd16; rd_bdf = 16'h0310; rd_addr = 32'h3000_0000;
        for (int i = 0; i < 10; i++) begin
            wr_addr = 32'h4000_0000 + 32'(i * 64);
            wr_data = mk_data(32'(i));
            rd_addr = 32'h3000_0000 + 32'(i * 128);
            cyc();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        cyc(); cyc();
        n_vec++;
        if (glog != "WWWWRWWWWR") begin
            n_err++;
            $display("FAIL grant_order: got %s expected WWWWRWWWWR", glog);
        end
        chk("burst_ph", ph_avail, 8);
        chk("burst_pd", pd_avail, 64);
        chk("burst_nph", nph_avail, 8);

        // Drain PD to 4 using only header returns
        auto_d = 0;
        wr_valid = 1'b1; wr_length = 8'd16; wr_addr = 32'h5000_0000;
        repeat (15) cyc();
        wr_valid = 1'b0;
        cyc(); cyc();
        chk("drain_pd", pd_avail, 4);
        chk("drain_ph", ph_avail, 8);

        // Credit-starved write must not block a read
        wr_valid = 1'b1; wr_length = 8'd20; wr_addr = 32'h5100_0000; wr_data = mk_data(32'hcafe);
        rd_valid = 1'b1; rd_length = 8'd8; rd_addr = 32'h6000_0000;
        #1;
        chk("starve_wr_ready", wr_ready, 0);
        chk("starve_rd_ready", rd_ready, 1);
        cyc();
        rd_valid = 1'b0;
        #1;
        chk("starve_tx_mrd", tx_is_memwrite, 0);
        chk("starve_nph", nph_avail, 7);
        chk("starve_wr_held", wr_ready, 0);
        cyc();
        pd_ret = 4'd1;
        cyc();
        pd_ret = 4'd0;
        #1;
        chk("unstarve_pd", pd_avail, 5);
        chk("unstarve_wr_ready", wr_ready, 1);
        cyc();
        wr_valid = 1'b0;
        #1;
        chk("unstarve_tx_mwr", tx_is_memwrite, 1);
        chk("unstarve_len", tx_length, 20);
        chk("unstarve_pd0", pd_avail, 0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            pd_ret = (i < 4) ? 4'd15 : 4'd4;
            cyc();
        end
        pd_ret = 4'd0;
        #1 chk("refill_pd", pd_avail, 64);

        // Downstream stall with slot full
        auto_d = 1;
        wr_valid = 1'b1; wr_length = 8'd8; wr_addr = 32'h2000_0000; wr_data = mk_data(32'h77);
        cyc();
        tx_ready = 1'b0; wr_addr = 32'h2000_1000;
        rd_valid = 1'b1; rd_length = 8'd4; rd_addr = 32'h6100_0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_tx_valid", tx_valid, 1);
            chk("stall_addr", tx_addr, 32'h2000_0000);
            chk("stall_wr_ready", wr_ready, 0);
            chk("stall_rd_ready", rd_ready, 0);
            chk("stall_ph", ph_avail, 7);
            chk("stall_pd", pd_avail, 62);
            cyc();
        end
        tx_ready = 1'b1;
        repeat (4) cyc();
        wr_valid = 1'b0; rd_valid = 1'b0;
        cyc(); cyc();

        // Mid-operation reset with NPH exhausted and a read stuck in the slot
        auto_h = 0; auto_d = 0;
        rd_valid = 1'b1; rd_length = 8'd4;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 32'h7000_0000 + 32'(i * 16);
            cyc();
        end
        tx_ready = 1'b0;
        #1;
        chk("mid_nph0", nph_avail, 0);
        chk("mid_full", tx_valid, 1);
        chk("mid_rd_blocked", rd_ready, 0);
        cyc();
        rst_n = 1'b0;
        cyc();
        #1;
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_nph", nph_avail, 8);
        chk("mid_rst_ph", ph_avail, 8);
        chk("mid_rst_pd", pd_avail, 64);
        chk("mid_rst_rd_ready", rd_ready, 0);
        rst_n = 1'b1;
        #1 chk("post_rst_rd_ready", rd_ready, 1);
        cyc();
        #1;
        chk("post_rst_tx_valid", tx_valid, 1);
        chk("post_rst_mrd", tx_is_memwrite, 0);
        chk("post_rst_nph", nph_avail, 7);
        rd_valid = 1'b0; tx_ready = 1'b1;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
